// File: rtl/tdes_sequencer.sv
// tdes_sequencer -- drives one single-DES core through three passes to form
// a 3DES operation (encrypt: E(k1) D(k2) E(k3); decrypt: D(k3) E(k2) D(k1)).
//
// Optional build macro: TDES_TIMEOUT_EN -- adds an 8-bit WAIT timeout counter
// that abandons a pass after TIMEOUT_CYCLES cycles and sets the sticky error.
//
// Ports:
//   HCLK, HRESET           clock (rising edge) / async active-low reset
//   enable                 start request; sampled in IDLE only
//   encryptionType         1 = encrypt, 0 = decrypt
//   data, key1..key3       input block and DES keys (snapshotted on accept)
//   des_start              one-cycle start pulse to the DES core
//   des_decrypt/key/data   per-pass direction, key and block (held per pass)
//   des_done, des_result   completion pulse and result from the DES core
//   outputEnable/Data      final result valid flag and value (held)
//   busy                   high in every state except IDLE
//   overrun                sticky: enable seen while busy
//   error                  sticky: a DES pass timed out (0 without the macro)
module tdes_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        enable,
  input  logic        encryptionType,
  input  logic [63:0] data,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  input  logic [63:0] key3,
  output logic        des_start,
  output logic        des_decrypt,
  output logic [63:0] des_key,
  output logic [63:0] des_data,
  input  logic        des_done,
  input  logic [63:0] des_result,
  output logic        outputEnable,
  output logic [63:0] outputData,
  output logic        busy,
  output logic        overrun,
  output logic        error
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("tdes_sequencer: TIMEOUT_CYCLES must be in 1..256");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t      st;
  logic [1:0]  pass;
  logic        enc_q;
  logic [63:0] k1_q, k2_q, k3_q;
  logic [63:0] work;

`ifdef TDES_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tcnt;
  logic       err_q;
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign busy = (st != IDLE);

  // Key for pass p: encrypt walks k1,k2,k3; decrypt walks k3,k2,k1.
  function automatic logic [63:0] pass_key(input logic enc, input logic [1:0] p,
                                           input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c);
    case (p)
      2'd0:    return enc ? a : c;
      2'd1:    return b;
      default: return enc ? c : a;
    endcase
  endfunction

  // The middle pass always runs opposite to the overall direction.
  function automatic logic pass_dec(input logic enc, input logic [1:0] p);
    return enc ? (p == 2'd1) : (p != 2'd1);
  endfunction

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      st           <= IDLE;
      pass         <= '0;
      enc_q        <= 1'b0;
      k1_q         <= '0;
      k2_q         <= '0;
      k3_q         <= '0;
      work         <= '0;
      des_start    <= 1'b0;
      des_decrypt  <= 1'b0;
      des_key      <= '0;
      des_data     <= '0;
      outputEnable <= 1'b0;
      outputData   <= '0;
      overrun      <= 1'b0;
`ifdef TDES_TIMEOUT_EN
      tcnt         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      des_start <= 1'b0;
      case (st)
        IDLE: begin
          if (enable) begin
            enc_q        <= encryptionType;
            k1_q         <= key1;
            k2_q         <= key2;
            k3_q         <= key3;
            work         <= data;
            pass         <= '0;
            overrun      <= 1'b0;
            outputEnable <= 1'b0;
`ifdef TDES_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
            // Pass 0 is loaded straight from the inputs on the accept edge
            // so des_start can be high during the START cycle itself.
            des_start    <= 1'b1;
            des_key      <= encryptionType ? key1 : key3;
            des_data     <= data;
            des_decrypt  <= ~encryptionType;
            st           <= START;
          end
        end
        START: begin
          if (enable) overrun <= 1'b1;
`ifdef TDES_TIMEOUT_EN
          tcnt <= '0;
`endif
          st <= WAIT;
        end
        WAIT: begin
          if (enable) overrun <= 1'b1;
          if (des_done) begin
            work <= des_result;
            if (pass != 2'd2) begin
              pass        <= pass + 2'd1;
              des_start   <= 1'b1;
              des_key     <= pass_key(enc_q, pass + 2'd1, k1_q, k2_q, k3_q);
              des_decrypt <= pass_dec(enc_q, pass + 2'd1);
              des_data    <= des_result;
              st          <= START;
            end else begin
              st <= DONE;
            end
          end
`ifdef TDES_TIMEOUT_EN
          else if (tcnt == TO_LAST) begin
            err_q <= 1'b1;
            st    <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        DONE: begin
          if (enable) overrun <= 1'b1;
          outputData   <= work;
          outputEnable <= 1'b1;
          st           <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdes_sequencer.sv
// Self-checking bench for tdes_sequencer. A behavioural DES-core stand-in
// (an invertible keyed mix, L-cycle start-to-done delay) answers each pass;
// a scoreboard holds the expected 3DES result per accepted operation and a
// monitor compares it, with latency, whenever outputEnable rises.
module tb_tdes_sequencer;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        enable = 1'b0;
  logic        encryptionType = 1'b0;
  logic [63:0] data = '0, key1 = '0, key2 = '0, key3 = '0;
  logic        des_start, des_decrypt;
  logic [63:0] des_key, des_data;
  logic        des_done = 1'b0;
  logic [63:0] des_result = '0;
  logic        outputEnable;
  logic [63:0] outputData;
  logic        busy, overrun, error;

  tdes_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .enable(enable), .encryptionType(encryptionType),
    .data(data), .key1(key1), .key2(key2), .key3(key3),
    .des_start(des_start), .des_decrypt(des_decrypt), .des_key(des_key),
    .des_data(des_data), .des_done(des_done), .des_result(des_result),
    .outputEnable(outputEnable), .outputData(outputData), .busy(busy),
    .overrun(overrun), .error(error)
  );

  always #5 HCLK = ~HCLK;

  int unsigned cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // ---------------- reference cipher and 3DES model ----------------
  function automatic logic [63:0] enc_f(input logic [63:0] k, input logic [63:0] x);
    logic [63:0] y;
    y = x ^ k;
    y = {y[50:0], y[63:51]};
    return y + k;
  endfunction

  function automatic logic [63:0] dec_f(input logic [63:0] k, input logic [63:0] y);
    logic [63:0] x;
    x = y - k;
    x = {x[12:0], x[63:13]};
    return x ^ k;
  endfunction

  function automatic logic [63:0] model_pass(input bit dec, input logic [63:0] k, input logic [63:0] x);
    return dec ? dec_f(k, x) : enc_f(k, x);
  endfunction

  function automatic logic [63:0] model_tdes(input bit enc, input logic [63:0] a,
                                             input logic [63:0] b, input logic [63:0] c,
                                             input logic [63:0] d);
    if (enc) return enc_f(c, dec_f(b, enc_f(a, d)));
    else     return dec_f(a, enc_f(b, dec_f(c, d)));
  endfunction

  // ---------------- DES core stand-in ----------------
  int          core_lat = 16;
  bit          core_mute = 1'b0;
  int          starts = 0;
  logic [63:0] klog[$];
  logic [63:0] xlog[$];
  bit          dlog[$];
  bit          pend = 1'b0;
  int          ccnt = 0;
  logic [63:0] cap_k, cap_d;
  logic        cap_dec;

  always @(negedge HCLK) begin
    des_done = 1'b0;
    if (pend) begin
      if (HRESET && busy) begin
        check64("pass_inputs_stable", {des_key ^ des_data, 63'(0), des_decrypt},
                {cap_k ^ cap_d, 63'(0), cap_dec});
      end
      ccnt--;
      if (ccnt == 0) begin
        des_done   = 1'b1;
        des_result = model_pass(cap_dec, cap_k, cap_d);
        pend       = 1'b0;
      end
    end
    if (des_start && !core_mute) begin
      starts++;
      klog.push_back(des_key);
      xlog.push_back(des_data);
      dlog.push_back(des_decrypt);
      cap_k   = des_key;
      cap_d   = des_data;
      cap_dec = des_decrypt;
      pend    = 1'b1;
      ccnt    = core_lat;
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic [63:0] res;
    int unsigned t0;
    int          lat;
  } exp_t;
  exp_t sb[$];
  logic prev_oe = 1'b0;

  always @(negedge HCLK) begin
    exp_t e;
    if (outputEnable && !prev_oe) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_output: got outputEnable=1 data %h, required no output", outputData);
      end else begin
        e = sb.pop_front();
        check64("result", outputData, e.res);
        check64("latency", 64'(cyc - e.t0), 64'(3 * (e.lat + 1) + 1));
      end
    end
    prev_oe = outputEnable;
  end

  // ---------------- stimulus ----------------
  logic [63:0] last_exp = '0;

  task automatic run_op(input bit enc, input logic [63:0] d, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c,
                        input int hold, input bit ov, input bit scramble);
    int          sbase, lbase;
    exp_t        e;
    logic [63:0] ks[3];
    bit          ds[3];
    logic [63:0] x;
    sbase = starts;
    lbase = klog.size();
    @(negedge HCLK);
    encryptionType = enc; data = d; key1 = a; key2 = b; key3 = c; enable = 1'b1;
    @(posedge HCLK); #1;
    e.t0 = cyc; e.res = model_tdes(enc, a, b, c, d); e.lat = core_lat;
    sb.push_back(e);
    last_exp = e.res;
    repeat (hold) begin @(posedge HCLK); #1; end
    enable = 1'b0;
    if (scramble) begin
      data = {$urandom, $urandom}; key1 = {$urandom, $urandom};
      key2 = {$urandom, $urandom}; key3 = {$urandom, $urandom};
      encryptionType = ~enc;
    end
    if (ov) begin
      for (int i = 0; i < 200; i++) begin
        @(negedge HCLK);
        if (starts - sbase >= 2) break;
      end
      repeat (3) @(negedge HCLK);
      enable = 1'b1;
      @(posedge HCLK); #1;
      enable = 1'b0;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge HCLK);
      if (!busy) break;
    end
    check64("op_completes_busy", 64'(busy), 64'(0));
    @(negedge HCLK);
    check64("scoreboard_drained", 64'(sb.size()), 64'(0));
    check64("start_pulses", 64'(starts - sbase), 64'(3));
    check64("overrun", 64'(overrun), 64'(hold > 0 || ov));
    check64("error", 64'(error), 64'(0));
    if (enc) begin ks = '{a, b, c}; ds = '{0, 1, 0}; end
    else     begin ks = '{c, b, a}; ds = '{1, 0, 1}; end
    x = d;
    if (klog.size() >= lbase + 3) begin
      for (int p = 0; p < 3; p++) begin
        check64($sformatf("pass%0d_key", p), klog[lbase + p], ks[p]);
        check64($sformatf("pass%0d_decrypt", p), 64'(dlog[lbase + p]), 64'(ds[p]));
        check64($sformatf("pass%0d_block", p), xlog[lbase + p], x);
        x = model_pass(ds[p], ks[p], x);
      end
    end
  endtask

  localparam logic [63:0] K  = 64'h0123456789ABCDEF;
  localparam logic [63:0] PT = 64'h4E6F772069732074;

  initial begin
    int sbase;
    HRESET = 1'b0;
    repeat (3) @(negedge HCLK);
    check64("rst_des_start", 64'(des_start), 64'(0));
    check64("rst_des_decrypt", 64'(des_decrypt), 64'(0));
    check64("rst_des_key", des_key, 64'(0));
    check64("rst_des_data", des_data, 64'(0));
    check64("rst_outputEnable", 64'(outputEnable), 64'(0));
    check64("rst_outputData", outputData, 64'(0));
    check64("rst_busy", 64'(busy), 64'(0));
    check64("rst_overrun", 64'(overrun), 64'(0));
    check64("rst_error", 64'(error), 64'(0));
    HRESET = 1'b1;

    // Equal keys collapse 3DES to a single pass; then round-trip back.
    run_op(1'b1, PT, K, K, K, 0, 1'b0, 1'b0);
    check64("single_equiv", outputData, enc_f(K, PT));
    run_op(1'b0, enc_f(K, PT), K, K, K, 0, 1'b0, 1'b0);
    check64("round_trip", outputData, PT);

    // Distinct keys: schedule order in both directions.
    run_op(1'b1, 64'hA5A5_0F0F_1234_5678, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, 0, 1'b0, 1'b0);
    run_op(1'b0, 64'hA5A5_0F0F_1234_5678, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, 0, 1'b0, 1'b0);

    // Overrun pulse during pass 1, held enable, post-snapshot input changes.
    run_op(1'b1, PT, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, 0, 1'b1, 1'b0);
    run_op(1'b0, PT, {16{4'h4}}, {16{4'h5}}, {16{4'h6}}, 3, 1'b0, 1'b1);

    for (int n = 0; n < 16; n++) begin
      core_lat = $urandom_range(2, 20);
      run_op(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    // Reset during pass 2 WAIT; the core's late done must be ignored.
    core_lat = 16;
    sbase = starts;
    @(negedge HCLK);
    encryptionType = 1'b1; data = PT; key1 = K; key2 = ~K; key3 = K ^ 64'h55; enable = 1'b1;
    @(posedge HCLK); #1;
    enable = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge HCLK);
      if (starts - sbase >= 3) break;
    end
    repeat (4) @(negedge HCLK);
    check64("mid_busy", 64'(busy), 64'(1));
    HRESET = 1'b0;
    #1;
    check64("mid_rst_des_start", 64'(des_start), 64'(0));
    check64("mid_rst_des_decrypt", 64'(des_decrypt), 64'(0));
    check64("mid_rst_des_key", des_key, 64'(0));
    check64("mid_rst_des_data", des_data, 64'(0));
    check64("mid_rst_outputEnable", 64'(outputEnable), 64'(0));
    check64("mid_rst_outputData", outputData, 64'(0));
    check64("mid_rst_busy", 64'(busy), 64'(0));
    check64("mid_rst_overrun", 64'(overrun), 64'(0));
    last_exp = '0;
    @(negedge HCLK);
    HRESET = 1'b1;
    repeat (30) @(negedge HCLK);
    check64("late_done_busy", 64'(busy), 64'(0));
    check64("late_done_outputEnable", 64'(outputEnable), 64'(0));
    check64("late_done_outputData", outputData, 64'(0));
    check64("late_done_starts", 64'(starts - sbase), 64'(3));

    run_op(1'b1, 64'hDEAD_BEEF_0BAD_F00D, K, ~K, K ^ 64'h55, 1, 1'b0, 1'b0);

`ifdef TDES_TIMEOUT_EN
    begin
      int unsigned t0;
      core_mute = 1'b1;
      @(negedge HCLK);
      encryptionType = 1'b1; data = PT; enable = 1'b1;
      @(posedge HCLK); #1;
      t0 = cyc;
      enable = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge HCLK);
        if (!busy) break;
      end
      check64("timeout_cycles", 64'(cyc - t0), 64'(65));
      check64("timeout_error", 64'(error), 64'(1));
      check64("timeout_busy", 64'(busy), 64'(0));
      check64("timeout_outputEnable", 64'(outputEnable), 64'(0));
      check64("timeout_outputData", outputData, last_exp);
      core_mute = 1'b0;
    end
`endif

    repeat (5) @(negedge HCLK);
    check64("final_scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tdes_sequencer.md
TDES_SEQUENCER -- requirements
Module: tdes_sequencer

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of WAIT cycles per DES pass (used only when TDES_TIMEOUT_EN is defined).
REQ-002 The module SHALL have these ports:
- HCLK  in  1  clock; all logic on the rising edge.
- HRESET  in  1  reset; asynchronous, active-low.
- enable  in  1  start request from the AHB-Lite slave controller.
- encryptionType  in  1  1 = encrypt, 0 = decrypt.
- data  in  64  input block.
- key1, key2, key3  in  64 each  DES keys.
- des_start  out  1  one-cycle start pulse to the single-DES core.
- des_decrypt  out  1  direction for the current pass; 1 = decrypt.
- des_key  out  64  key for the current pass.
- des_data  out  64  block for the current pass.
- des_done  in  1  one-cycle completion pulse from the DES core.
- des_result  in  64  DES core output; valid when des_done = 1.
- outputEnable  out  1  result valid; goes to the slave controller.
- outputData  out  64  final 3DES result.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; enable arrived while busy.
- error  out  1  sticky; a DES pass timed out.

Function
REQ-003 The FSM SHALL have four states: IDLE, START, WAIT, DONE.
REQ-004 In IDLE, enable = 1 SHALL snapshot encryptionType, data and key1..3 into internal registers, clear pass counter, overrun, error and outputEnable, and go to START.
REQ-005 In START, des_start SHALL be 1 for exactly one cycle and the FSM SHALL go to WAIT.
REQ-006 des_key, des_data and des_decrypt SHALL be registered and held stable from START until des_done is seen in WAIT.
REQ-007 The pass schedule SHALL be: encrypt = E(k1), D(k2), E(k3); decrypt = D(k3), E(k2), D(k1).
REQ-008 Pass 0 SHALL use the snapshot data as its block; passes 1 and 2 SHALL use the previous pass's des_result.
REQ-009 In WAIT, des_done = 1 SHALL latch des_result into the working register.
- If the pass counter is below 2: increment the counter and go to START.
- If the pass counter is 2: go to DONE.
REQ-010 des_done SHALL be ignored in IDLE, START and DONE.
REQ-011 On entering DONE, outputData SHALL be set to the final result and outputEnable to 1; the FSM SHALL go to IDLE on the next cycle.
REQ-012 outputEnable and outputData SHALL hold until the next accepted enable, which clears outputEnable on that same edge.
REQ-013 Latency SHALL be 3 × (L + 1) + 1 cycles from the accepted enable edge to outputEnable = 1, where L is the core's start-to-done delay in cycles.
REQ-014 enable = 1 in START, WAIT or DONE SHALL be ignored by the datapath and SHALL set overrun; no new operation is queued.
REQ-015 enable held high over several cycles in IDLE SHALL start exactly one operation; it is re-evaluated only after the FSM returns to IDLE.
REQ-016 Changes to data, keys or encryptionType after the snapshot SHALL NOT affect the operation in progress.

Reset
REQ-017 HRESET = 0 SHALL asynchronously force:
- FSM to IDLE, pass counter to 0.
- des_start, des_decrypt, outputEnable, busy, overrun, error to 0.
- outputData, des_key, des_data and all internal registers to 0.
REQ-018 Reset in the middle of an operation SHALL abandon it; a des_done arriving after reset is released SHALL be ignored per REQ-010.

Configuration
REQ-019 With TDES_TIMEOUT_EN defined:
- An 8-bit counter SHALL clear on entry to WAIT and increment each cycle in WAIT.
- When it reaches TIMEOUT_CYCLES without des_done, the FSM SHALL go to IDLE with error = 1, outputEnable = 0, and outputData unchanged.
REQ-020 Without TDES_TIMEOUT_EN, WAIT SHALL persist until des_done, error SHALL be tied to 0, and no timeout counter SHALL exist.

Verification
REQ-021 Single-DES equivalence: DES core model with L = 16; key1 = key2 = key3 = 0x0123456789ABCDEF, data = 0x4E6F772069732074, encryptionType = 1 -> outputData = 0x3FA40E8A984D4815 and outputEnable rises 52 cycles after enable.
REQ-022 Round trip: same keys, data = 0x3FA40E8A984D4815, encryptionType = 0 -> outputData = 0x4E6F772069732074; des_decrypt sequence observed as 1, 0, 1.
REQ-023 Schedule: key1 = 0x1111…, key2 = 0x2222…, key3 = 0x3333…, encrypt -> des_key sequence 0x1111…, 0x2222…, 0x3333… with des_decrypt 0, 1, 0; decrypt reverses the key order.
REQ-024 Overrun: enable pulse during pass 1 WAIT -> overrun = 1, result unchanged versus an undisturbed run, only 3 des_start pulses.
REQ-025 Reset mid-operation: HRESET low during pass 2 WAIT -> all outputs 0 immediately; a late des_done causes no state change.
REQ-026 Timeout (TDES_TIMEOUT_EN defined): core never asserts des_done -> after 64 WAIT cycles error = 1, busy = 0, outputEnable = 0.
